// File: rtl/booth_pkg.sv
// booth_pkg: shared constants, FSM state encoding and saturation limits for the booth_mul/booth_acc datapath
package booth_pkg;
  localparam int BOOTH_PROD_W = 8;
  localparam logic ST_ACCUM = 1'b0;
  localparam logic ST_HOLD = 1'b1;
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction
  function automatic logic [63:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction
endpackage

// File: rtl/booth_acc_add.sv
// booth_acc_add: sign-extending accumulator adder with signed overflow detect; saturates when BOOTH_ACC_SAT_EN is defined
// Ports: acc (current sum), prod (signed product), sum (next sum), ovf (signed overflow of this add).
module booth_acc_add
  import booth_pkg::*;
#(
  parameter int PROD_W = BOOTH_PROD_W,
  parameter int ACC_W = 16
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);
  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] raw;
  assign ext = ACC_W'($signed(prod));
  assign raw = acc + ext;
  assign ovf = (acc[ACC_W-1] == ext[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]);
`ifdef BOOTH_ACC_SAT_EN
  localparam logic [63:0] MAX64 = sat_max(ACC_W);
  localparam logic [63:0] MIN64 = sat_min(ACC_W);
  // on overflow both operands share acc's sign, so it picks the rail
  assign sum = !ovf ? raw : acc[ACC_W-1] ? MIN64[ACC_W-1:0] : MAX64[ACC_W-1:0];
`else
  assign sum = raw;
`endif
endmodule

// File: rtl/booth_acc.sv
// booth_acc: accumulates BLOCK_LEN signed booth_mul products per block and hands the sum out on a valid/ready handshake
// Ports: clk, rst (async, active-high), clear (sync flush), in_valid/in_ready/in_prod (product input),
//        out_valid/out_ready/out_acc/out_ovf (block result), cnt (products accepted this block).
// Macro BOOTH_ACC_SAT_EN: saturate each add on overflow instead of wrapping.
module booth_acc
  import booth_pkg::*;
#(
  parameter int PROD_W = BOOTH_PROD_W,
  parameter int ACC_W = 16,
  parameter int BLOCK_LEN = 4,
  localparam int CNT_W = $clog2(BLOCK_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf,
  output logic [CNT_W-1:0]  cnt
);
  logic state, state_nx;
  logic [ACC_W-1:0] acc, sum;
  logic ovf_sticky, add_ovf;
  logic accept, last, take;
  booth_acc_add #(.PROD_W(PROD_W), .ACC_W(ACC_W)) u_add (
    .acc(acc),
    .prod(in_prod),
    .sum(sum),
    .ovf(add_ovf)
  );
  assign accept = in_valid && in_ready && !clear;
  assign last = accept && (cnt == CNT_W'(BLOCK_LEN - 1));
  assign take = out_valid && out_ready && !clear;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_ACCUM;
    else state <= state_nx;
  always_comb
    state_nx = clear ? ST_ACCUM :
               state == ST_ACCUM ? (last ? ST_HOLD : ST_ACCUM) :
               (out_ready ? ST_ACCUM : ST_HOLD);
  always_comb begin
    in_ready = state == ST_ACCUM;
    out_valid = state == ST_HOLD;
    out_ovf = out_valid && ovf_sticky;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      ovf_sticky <= 1'b0;
      out_acc <= '0;
    end else if (clear || take) begin
      acc <= '0;
      cnt <= '0;
      ovf_sticky <= 1'b0;
    end else if (accept) begin
      acc <= sum;
      cnt <= cnt + CNT_W'(1);
      ovf_sticky <= ovf_sticky | add_ovf;
      if (last) out_acc <= sum;
    end
endmodule
